hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the RV core. It generalises single-cycle load-use detection in four ways:
- multi-cycle load latency, held by a stall counter;
- a pending-write scoreboard for the long-latency arithmetic unit (FFT multiplier/butterfly);
- branch-flush control;
- x0 and unused-operand filtering.

It sits beside the IF/ID and ID/EX registers and drives the PC, IF/ID and ID/EX hold and flush controls.

Parameters:
- REG_AW, 5, register address width.
- NUM_REGS, 32, architectural register count (scoreboard depth).
- LOAD_LAT, 1, cycles from load in EX until data is forwardable (>=1).
- MAX_OUTSTANDING, 4, maximum in-flight long-latency ops (>=1).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- ifid_reg1_raddr  in  REG_AW  source 1 of the instruction in ID.
- ifid_reg1_ren  in  1  source 1 is used.
- ifid_reg2_raddr  in  REG_AW  source 2 of the instruction in ID.
- ifid_reg2_ren  in  1  source 2 is used.
- ifid_reg_waddr  in  REG_AW  destination of the instruction in ID.
- ifid_reg_wena  in  1  ID instruction writes a register.
- idex_reg_waddr  in  REG_AW  destination of the instruction in EX.
- idex_mem_rena  in  1  EX instruction is a load.
- lu_issue  in  1  long-latency op issued from EX this cycle.
- lu_issue_waddr  in  REG_AW  its destination.
- lu_done  in  1  long-latency op writes back this cycle.
- lu_done_waddr  in  REG_AW  its destination.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- pc_hold  out  1  freeze PC.
- ifid_hold  out  1  freeze IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- ifid_flush  out  1  load NOP into IF/ID.
- lu_full  out  1  MAX_OUTSTANDING ops in flight.

Behaviour:
- Reset: rst is synchronous and active-high on clk. Reset clears load_cnt, the scoreboard and outst_cnt. Every output is 0 during the reset cycle and in the first cycle after it.
- Source match (src_hit): a source matches an address only when its ren=1 and the address is not 0. x0 never hazards.
- Load-use detection (load_hit): idex_mem_rena=1, idex_reg_waddr!=0, and src_hit against idex_reg_waddr.
  - In cycle N of a load_hit: pc_hold=ifid_hold=idex_bubble=1.
  - At the end of N, load_cnt is loaded with LOAD_LAT-1.
  - While load_cnt!=0 the same three outputs stay 1 and load_cnt decrements each cycle.
  - Total stall is exactly LOAD_LAT cycles.
  - load_hit is ignored while load_cnt!=0, because the EX stage then holds a bubble.
- Scoreboard: NUM_REGS bits plus outst_cnt (width clog2(MAX_OUTSTANDING+1)).
  - lu_issue sets bit[lu_issue_waddr]; lu_done clears bit[lu_done_waddr].
  - Same address issued and done in the same cycle: the bit ends set.
  - Writes to x0 are never recorded.
  - outst_cnt increments on issue, decrements on done, and is unchanged when both occur.
- Scoreboard hazard (sb_hit): either of the following asserts pc_hold, ifid_hold and idex_bubble for as long as it persists:
  - RAW: a used source whose scoreboard bit is set;
  - WAW: ifid_reg_wena with the bit for ifid_reg_waddr set.
- lu_full: equals (outst_cnt==MAX_OUTSTANDING). The EX issue logic must not assert lu_issue while lu_full=1. An issue at full is ignored and the counter saturates. This is an assertion target.
- Branch flush: ex_branch_taken asserts ifid_flush=1 and idex_bubble=1 and forces pc_hold=ifid_hold=0 in the same cycle. It also clears load_cnt. The scoreboard is unaffected, because issued ops are architectural.
- Priority: rst > flush > load stall > scoreboard stall.
- Latency: all outputs are combinational from registered state plus the current inputs. Registered state updates on clk.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, two output ports are added:
  - stall_cnt[31:0]: increments on each cycle with pc_hold=1.
  - flush_cnt[31:0]: increments on each ex_branch_taken.
  - Both wrap at 2^32 and are cleared by rst.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package/define file carries:
  - `funEnable/`funDisable;
  - register address width;
  - REG_ZERO constant;
  - hazard-type encoding (NONE, LOAD, SCORE, FLUSH), exported for debug.
- One sub-module, hazard_scoreboard: owns the bit vector, outst_cnt and lu_full, and provides the RAW/WAW lookup.

Test Plan:
- LOAD_LAT=2: load writes x5 in EX, ID reads x5 via src1 -> pc_hold/ifid_hold/idex_bubble high for exactly 2 cycles, then low.
- Load writes x0, or the matching source has ren=0 -> no stall in any cycle.
- lu_issue x7; ID reads x7 for 6 cycles; lu_done x7 at cycle 6 -> hold in cycles 1-6, released in cycle 7. Repeat with issue and done of x7 in the same cycle -> bit stays set and the stall continues.
- Load-use stall at LOAD_LAT=3 with ex_branch_taken in the second stall cycle -> ifid_flush=1, pc_hold=0 that cycle; no hold in the following cycle.
- MAX_OUTSTANDING=4: 4 issues to x1-x4 -> lu_full=1; one lu_done -> lu_full=0 the next cycle; a 5th issue while full -> assertion fires and the count stays at 4.
- rst asserted mid-stall (load_cnt=2, scoreboard non-empty) -> all outputs 0 the next cycle and the scoreboard is empty. With HAZARD_PERF_CNT_EN defined, stall_cnt equals the counted hold cycles before reset and is 0 after it.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: enable literals, address width,
// x0 constant and the hazard-type debug encoding.
`ifndef HAZARD_CTRL_DEFS
`define HAZARD_CTRL_DEFS
`define funEnable  1'b1
`define funDisable 1'b0
`endif

package hazard_ctrl_pkg;

    localparam int HC_REG_AW = 5;
    localparam logic [HC_REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        HZ_NONE  = 2'd0,
        HZ_LOAD  = 2'd1,
        HZ_SCORE = 2'd2,
        HZ_FLUSH = 2'd3
    } hazard_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID/EX-side hazard bus: pipeline-stage register info in, hold/flush controls out.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int AW = HC_REG_AW
);
    logic [AW-1:0] ifid_reg1_raddr;
    logic          ifid_reg1_ren;
    logic [AW-1:0] ifid_reg2_raddr;
    logic          ifid_reg2_ren;
    logic [AW-1:0] ifid_reg_waddr;
    logic          ifid_reg_wena;
    logic [AW-1:0] idex_reg_waddr;
    logic          idex_mem_rena;
    logic          lu_issue;
    logic [AW-1:0] lu_issue_waddr;
    logic          lu_done;
    logic [AW-1:0] lu_done_waddr;
    logic          ex_branch_taken;
    logic          pc_hold;
    logic          ifid_hold;
    logic          idex_bubble;
    logic          ifid_flush;
    logic          lu_full;
    hazard_e       hz_type;

    modport master (
        output ifid_reg1_raddr, ifid_reg1_ren, ifid_reg2_raddr, ifid_reg2_ren,
               ifid_reg_waddr, ifid_reg_wena, idex_reg_waddr, idex_mem_rena,
               lu_issue, lu_issue_waddr, lu_done, lu_done_waddr, ex_branch_taken,
        input  pc_hold, ifid_hold, idex_bubble, ifid_flush, lu_full, hz_type
    );

    modport slave (
        input  ifid_reg1_raddr, ifid_reg1_ren, ifid_reg2_raddr, ifid_reg2_ren,
               ifid_reg_waddr, ifid_reg_wena, idex_reg_waddr, idex_mem_rena,
               lu_issue, lu_issue_waddr, lu_done, lu_done_waddr, ex_branch_taken,
        output pc_hold, ifid_hold, idex_bubble, ifid_flush, lu_full, hz_type
    );
endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Pending-write scoreboard for long-latency ops: one bit per register plus an
// in-flight counter; RAW/WAW lookup is combinational on registered state.
module hazard_scoreboard #(
    parameter int REG_AW          = 5,
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_waddr_i,
    input  logic              done_i,
    input  logic [REG_AW-1:0] done_waddr_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic              rs1_ren_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rs2_ren_i,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wena_i,
    output logic              raw_o,
    output logic              waw_o,
    output logic              full_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [CW-1:0]       outst_q, outst_d;
    logic                iss_eff, done_eff;

    assign full_o   = (outst_q == CW'(MAX_OUTSTANDING));
    assign iss_eff  = issue_i && !full_o;
    assign done_eff = done_i && (outst_q != '0);

    // Clear before set so a same-cycle issue/done to one register leaves it pending.
    always_comb begin
        sb_d = sb_q;
        if (done_i)
            sb_d[done_waddr_i] = 1'b0;
        if (iss_eff)
            sb_d[issue_waddr_i] = 1'b1;
        sb_d[0] = 1'b0;
        outst_d = outst_q;
        if (iss_eff && !done_eff)
            outst_d = outst_q + CW'(1);
        else if (!iss_eff && done_eff)
            outst_d = outst_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q    <= '0;
            outst_q <= '0;
        end else begin
            sb_q    <= sb_d;
            outst_q <= outst_d;
        end
    end

    assign raw_o = (rs1_ren_i && (rs1_i != '0) && sb_q[rs1_i]) ||
                   (rs2_ren_i && (rs2_i != '0) && sb_q[rs2_i]);
    assign waw_o = wena_i && (wd_i != '0) && sb_q[wd_i];

`ifndef SYNTHESIS
    issue_not_full_a: assert property (@(posedge clk) disable iff (rst) !(issue_i && full_o));
`endif
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall counter, long-latency scoreboard stall and
// branch flush. Outputs are combinational from state + inputs. Optional HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW          = HC_REG_AW,
    parameter int NUM_REGS        = 32,
    parameter int LOAD_LAT        = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    logic [LCW-1:0] load_cnt_q, load_cnt_d;
    logic           rst_dly_q;
    logic           quiet, load_hit, load_stall, sb_raw, sb_waw, sb_full;
    logic           pc_hold, idex_bubble, ifid_flush;
    hazard_e        hz_type;

    function automatic logic src_hit(input logic [REG_AW-1:0] src, input logic ren,
                                     input logic [REG_AW-1:0] addr);
        return ren && (src != REG_AW'(REG_ZERO)) && (src == addr);
    endfunction

    hazard_scoreboard #(
        .REG_AW(REG_AW), .NUM_REGS(NUM_REGS), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_sb (
        .clk(clk), .rst(rst),
        .issue_i(bus.lu_issue), .issue_waddr_i(bus.lu_issue_waddr),
        .done_i(bus.lu_done), .done_waddr_i(bus.lu_done_waddr),
        .rs1_i(bus.ifid_reg1_raddr), .rs1_ren_i(bus.ifid_reg1_ren),
        .rs2_i(bus.ifid_reg2_raddr), .rs2_ren_i(bus.ifid_reg2_ren),
        .wd_i(bus.ifid_reg_waddr), .wena_i(bus.ifid_reg_wena),
        .raw_o(sb_raw), .waw_o(sb_waw), .full_o(sb_full)
    );

    // Outputs stay silent in the reset cycle and the one after it.
    assign quiet    = rst || rst_dly_q;
    assign load_hit = !quiet && (load_cnt_q == '0) && bus.idex_mem_rena &&
                      (bus.idex_reg_waddr != REG_AW'(REG_ZERO)) &&
                      (src_hit(bus.ifid_reg1_raddr, bus.ifid_reg1_ren, bus.idex_reg_waddr) ||
                       src_hit(bus.ifid_reg2_raddr, bus.ifid_reg2_ren, bus.idex_reg_waddr));
    assign load_stall = load_hit || (load_cnt_q != '0);

    always_comb begin
        pc_hold     = `funDisable;
        idex_bubble = `funDisable;
        ifid_flush  = `funDisable;
        hz_type     = HZ_NONE;
        if (!quiet) begin
            if (bus.ex_branch_taken) begin
                ifid_flush  = `funEnable;
                idex_bubble = `funEnable;
                hz_type     = HZ_FLUSH;
            end else if (load_stall) begin
                pc_hold     = `funEnable;
                idex_bubble = `funEnable;
                hz_type     = HZ_LOAD;
            end else if (sb_raw || sb_waw) begin
                pc_hold     = `funEnable;
                idex_bubble = `funEnable;
                hz_type     = HZ_SCORE;
            end
        end
    end

    always_comb begin
        load_cnt_d = '0;
        if (bus.ex_branch_taken)
            load_cnt_d = '0;
        else if (load_cnt_q != '0)
            load_cnt_d = load_cnt_q - LCW'(1);
        else if (load_hit)
            load_cnt_d = LCW'(LOAD_LAT - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q <= '0;
            rst_dly_q  <= 1'b1;
        end else begin
            load_cnt_q <= load_cnt_d;
            rst_dly_q  <= 1'b0;
        end
    end

    assign bus.pc_hold     = pc_hold;
    assign bus.ifid_hold   = pc_hold;
    assign bus.idex_bubble = idex_bubble;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.lu_full     = sb_full && !quiet;
    assign bus.hz_type     = hz_type;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.ex_branch_taken)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal checks, then random traffic
// compared every cycle against a rule-level model of stalls, pending writes and flushes.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int LAT  = 3;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.AW(5)) bus ();
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_ctrl #(
        .REG_AW(5), .NUM_REGS(32), .LOAD_LAT(LAT), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: remaining load-stall cycles, set of pending registers, in-flight count.
    int          m_stall_left = 0;
    bit          m_pend[32];
    int          m_inflight   = 0;
    bit          m_after_rst  = 1'b1;
    logic [31:0] m_stalls     = 0;
    logic [31:0] m_flushes    = 0;

    bit      e_quiet, e_lh, e_sb, e_hold, e_bub, e_flush, e_full, e_iss;
    hazard_e e_hz;

    function automatic bit reads(input logic [4:0] src, input logic ren, input logic [4:0] a);
        return ren && src != 0 && src == a;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            e_quiet = rst || m_after_rst;
            e_lh = bus.idex_mem_rena && bus.idex_reg_waddr != 0 && m_stall_left == 0 &&
                   (reads(bus.ifid_reg1_raddr, bus.ifid_reg1_ren, bus.idex_reg_waddr) ||
                    reads(bus.ifid_reg2_raddr, bus.ifid_reg2_ren, bus.idex_reg_waddr));
            e_sb = (bus.ifid_reg1_ren && bus.ifid_reg1_raddr != 0 && m_pend[bus.ifid_reg1_raddr]) ||
                   (bus.ifid_reg2_ren && bus.ifid_reg2_raddr != 0 && m_pend[bus.ifid_reg2_raddr]) ||
                   (bus.ifid_reg_wena && bus.ifid_reg_waddr != 0 && m_pend[bus.ifid_reg_waddr]);
            e_hold = 0; e_bub = 0; e_flush = 0; e_full = 0; e_hz = HZ_NONE;
            if (!e_quiet) begin
                e_full = (m_inflight == MAXO);
                if (bus.ex_branch_taken) begin
                    e_flush = 1; e_bub = 1; e_hz = HZ_FLUSH;
                end else if (e_lh || m_stall_left > 0) begin
                    e_hold = 1; e_bub = 1; e_hz = HZ_LOAD;
                end else if (e_sb) begin
                    e_hold = 1; e_bub = 1; e_hz = HZ_SCORE;
                end
            end
            check("outputs{hold,ifhold,bub,flush,full,hz}",
                  {bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.ifid_flush, bus.lu_full, bus.hz_type},
                  {e_hold, e_hold, e_bub, e_flush, e_full, e_hz});
`ifdef HAZARD_PERF_CNT_EN
            if (!m_after_rst || !rst) begin
                check("stall_cnt", stall_cnt, m_stalls);
                check("flush_cnt", flush_cnt, m_flushes);
            end
`endif
            if (rst) begin
                m_stall_left = 0; m_inflight = 0; m_after_rst = 1;
                m_stalls = 0; m_flushes = 0;
                for (int i = 0; i < 32; i++) m_pend[i] = 0;
            end else begin
                if (e_hold) m_stalls++;
                if (bus.ex_branch_taken) m_flushes++;
                if (bus.ex_branch_taken) m_stall_left = 0;
                else if (m_stall_left > 0) m_stall_left--;
                else if (e_lh && !e_quiet) m_stall_left = LAT - 1;
                e_iss = bus.lu_issue && m_inflight < MAXO;
                if (bus.lu_done) m_pend[bus.lu_done_waddr] = 0;
                if (e_iss && bus.lu_issue_waddr != 0) m_pend[bus.lu_issue_waddr] = 1;
                if (e_iss) m_inflight++;
                if (bus.lu_done && m_inflight > 0) m_inflight--;
                m_after_rst = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ifid_reg1_raddr = 0; bus.ifid_reg1_ren = 0;
        bus.ifid_reg2_raddr = 0; bus.ifid_reg2_ren = 0;
        bus.ifid_reg_waddr  = 0; bus.ifid_reg_wena = 0;
        bus.idex_reg_waddr  = 0; bus.idex_mem_rena = 0;
        bus.lu_issue = 0; bus.lu_issue_waddr = 0;
        bus.lu_done  = 0; bus.lu_done_waddr  = 0;
        bus.ex_branch_taken = 0;
    endtask

    task automatic load_use(input logic [4:0] r);
        idle();
        bus.idex_mem_rena = 1; bus.idex_reg_waddr = r;
        bus.ifid_reg1_raddr = r; bus.ifid_reg1_ren = 1;
    endtask

    task automatic read1(input logic [4:0] r);
        idle();
        bus.ifid_reg1_raddr = r; bus.ifid_reg1_ren = 1;
    endtask

    logic [4:0] inflight_q[$];
    logic [4:0] a;
    int         k;

    initial begin
        idle();
        rst = 1;
        tick();
        chk_en = 1;
        // Hazard-shaped inputs during and right after reset must produce nothing.
        load_use(5'd5); bus.ex_branch_taken = 1;
        @(negedge clk); check("rst_cycle_flush", bus.ifid_flush, 1'b0);
        tick(); rst = 0; load_use(5'd5);
        @(negedge clk); check("post_rst_hold", bus.pc_hold, 1'b0);
        tick(); idle(); tick();

        // Load-use on x5: exactly LAT hold cycles.
        load_use(5'd5);
        @(negedge clk); check("ld_c0_hold", bus.pc_hold, 1'b1);
        tick(); read1(5'd5);
        @(negedge clk); check("ld_c1_ifhold", bus.ifid_hold, 1'b1);
        tick();
        @(negedge clk); check("ld_c2_bubble", bus.idex_bubble, 1'b1);
        tick();
        @(negedge clk); check("ld_c3_release", bus.pc_hold, 1'b0);
        tick();

        // Load to x0 / unused matching source: no stall.
        load_use(5'd0);
        @(negedge clk); check("ld_x0_hold", bus.pc_hold, 1'b0);
        tick(); load_use(5'd5); bus.ifid_reg1_ren = 0;
        @(negedge clk); check("ld_noren_hold", bus.pc_hold, 1'b0);
        tick(); idle(); tick();

        // Scoreboard RAW on x7, released the cycle after done.
        bus.lu_issue = 1; bus.lu_issue_waddr = 7;
        tick();
        for (int c = 1; c <= 7; c++) begin
            read1(5'd7);
            if (c == 6) begin bus.lu_done = 1; bus.lu_done_waddr = 7; end
            @(negedge clk);
            if (c == 1) check("sb_c1_hold", bus.pc_hold, 1'b1);
            if (c == 6) check("sb_c6_hold", bus.pc_hold, 1'b1);
            if (c == 7) check("sb_c7_release", bus.pc_hold, 1'b0);
            tick();
        end
        idle(); bus.lu_issue = 1; bus.lu_issue_waddr = 7;
        tick(); read1(5'd7);
        bus.lu_issue = 1; bus.lu_issue_waddr = 7; bus.lu_done = 1; bus.lu_done_waddr = 7;
        tick(); read1(5'd7); bus.lu_done = 1; bus.lu_done_waddr = 7;
        @(negedge clk); check("sb_same_cycle_hold", bus.pc_hold, 1'b1);
        tick(); read1(5'd7);
        @(negedge clk); check("sb_same_cycle_release", bus.pc_hold, 1'b0);
        tick();

        // Branch during a load stall wins and clears the remaining stall.
        load_use(5'd5);
        @(negedge clk); check("fl_stall", bus.pc_hold, 1'b1);
        tick(); read1(5'd5); bus.ex_branch_taken = 1;
        @(negedge clk); check("fl_flush", bus.ifid_flush, 1'b1);
        check("fl_hold_forced_low", bus.pc_hold, 1'b0);
        tick(); read1(5'd5);
        @(negedge clk); check("fl_after_hold", bus.pc_hold, 1'b0);
        tick();

        // Four issues fill the scoreboard; one done frees a slot a cycle later.
        for (int i = 1; i <= 4; i++) begin
            idle(); bus.lu_issue = 1; bus.lu_issue_waddr = 5'(i);
            tick();
        end
        idle(); bus.lu_done = 1; bus.lu_done_waddr = 1;
        @(negedge clk); check("full_at_4", bus.lu_full, 1'b1);
        tick(); idle();
        @(negedge clk); check("full_after_done", bus.lu_full, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            idle(); bus.lu_done = 1; bus.lu_done_waddr = 5'(i);
            tick();
        end

        // Reset in the middle of a load stall with x9 pending.
        idle(); bus.lu_issue = 1; bus.lu_issue_waddr = 9;
        tick(); load_use(5'd5);
        @(negedge clk); check("mr_stall", bus.pc_hold, 1'b1);
        tick(); read1(5'd9); rst = 1;
        @(negedge clk); check("mr_rst_hold", bus.pc_hold, 1'b0);
        tick(); rst = 0; read1(5'd9);
        @(negedge clk); check("mr_quiet_hold", bus.pc_hold, 1'b0);
        tick(); read1(5'd9);
        @(negedge clk); check("mr_sb_empty", bus.pc_hold, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        check("mr_stall_cnt_cleared", stall_cnt, 32'd0);
`endif
        tick();

        // Random traffic; the model check runs every cycle.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            bus.ifid_reg1_raddr = 5'($urandom_range(0, 7)); bus.ifid_reg1_ren = 1'($urandom);
            bus.ifid_reg2_raddr = 5'($urandom_range(0, 7)); bus.ifid_reg2_ren = 1'($urandom);
            bus.ifid_reg_waddr  = 5'($urandom_range(0, 7)); bus.ifid_reg_wena = 1'($urandom);
            bus.idex_reg_waddr  = 5'($urandom_range(0, 7));
            bus.idex_mem_rena   = ($urandom_range(0, 2) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
            if (rst) begin
                inflight_q.delete();
            end else begin
                if (inflight_q.size() > 0 && $urandom_range(0, 3) == 0) begin
                    k = $urandom_range(0, inflight_q.size() - 1);
                    bus.lu_done = 1; bus.lu_done_waddr = inflight_q[k];
                    inflight_q.delete(k);
                end
                if (inflight_q.size() + (bus.lu_done ? 1 : 0) < MAXO && $urandom_range(0, 3) == 0) begin
                    a = 5'($urandom_range(1, 7));
                    bus.lu_issue = 1; bus.lu_issue_waddr = a;
                    inflight_q.push_back(a);
                end
            end
            tick();
        end
        rst = 0; idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
